uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter: OVERSAMPLE, 16, clk cycles per UART bit. This value matches the receiver sampling rate and is fixed for this release.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 data_in  input  8  byte to transmit; sampled only on the accept edge.
REQ-005 tx_valid  input  1  upstream asserts when data_in is valid.
REQ-006 tx_ready  output  1  high exactly when state==IDLE; combinational from state.
REQ-007 tx  output  1  UART serial line; registered; idle level 1.
REQ-008 busy  output  1  high whenever state!=IDLE.
REQ-009 done  output  8'd0-free 1-bit  single-cycle pulse marking frame completion; registered.

Function
REQ-010 The block SHALL implement states IDLE, START, DATA, STOP; any unused encoding SHALL return to IDLE.
REQ-011 Accept rule: a byte is accepted on a rising edge where tx_valid && tx_ready. On that edge the block SHALL:
  - load data_in into an 8-bit shift register;
  - clear the bit-period counter (4 bits) and the bit index (3 bits);
  - set tx<=0;
  - enter START.
REQ-012 START SHALL hold tx=0 for 16 cycles, counting 0..15. At count 15 it SHALL set tx to data bit 0, clear the counter and enter DATA.
REQ-013 DATA SHALL send bits LSB first, each held for 16 cycles. At count 15 it SHALL:
  - if bit index <7: advance the index and drive the next bit;
  - if bit index ==7: set tx<=1 and enter STOP.
REQ-014 STOP SHALL hold tx=1 for 16 cycles. At count 15 it SHALL enter IDLE and set done<=1 for exactly one cycle.
REQ-015 The frame length from the accept edge to the IDLE re-entry edge SHALL be exactly 160 cycles.
REQ-016 Back-to-back transfers:
  - the earliest next accept is the first edge after IDLE re-entry;
  - the line is therefore high for at least 17 cycles between frames;
  - no other inter-frame gap SHALL be inserted.
REQ-017 tx_valid while busy SHALL be ignored: no capture, no queuing.
REQ-018 Changes on data_in after the accept edge SHALL NOT affect the frame in flight.
REQ-019 The bit-period counter SHALL wrap 15->0 only on the terminal-count edges named above.
REQ-020 done SHALL be 0 in every cycle except the first cycle after STOP completes.
REQ-021 tx SHALL never glitch, because it is driven only from a flop.

Reset
REQ-022 While rst=1, outputs SHALL be: tx=1, done=0, busy=0, tx_ready=1. State SHALL be IDLE and all counters and the shift register SHALL be 0.
REQ-023 Reset asserted mid-frame SHALL abort immediately and asynchronously: tx returns to 1, no done pulse, the partial frame is discarded.
REQ-024 After rst deasserts, the first accept MAY occur on the first rising edge.

Structure
REQ-025 The following SHALL live in shared include uart_defs.vh, used by both uart_tx and the existing receiver:
  - state encodings IDLE/START/DATA/STOP;
  - OVERSAMPLE=16;
  - frame constants: 8 data bits, 1 stop bit.
REQ-026 The design SHALL be a single flat module with no sub-module. The bit-period counter is inline, because a separate baud generator would add no reuse at a fixed 16x ratio.

Verification
REQ-027 Reset check: assert rst at arbitrary times -> tx=1, tx_ready=1, busy=0, done=0, all within the same cycle.
REQ-028 Single frame, data_in=8'hA5 -> tx per 16-cycle bit: 0,1,0,1,0,0,1,0,1,1. done pulses once at cycle 160 after the accept edge, and busy is high for cycles 1..160.
REQ-029 Loopback: drive tx into the team's UART receiver on the same clk and send 8'h3C -> receiver data_out=8'h3C with one done pulse. Repeat for 8'h00, 8'hFF, 8'h81.
REQ-030 Back-to-back, tx_valid held high with 8'h00 then 8'hFF:
  - second start-bit falling edge occurs exactly 161 cycles after the first accept;
  - line is high for 17 cycles between frames;
  - both bytes are received correctly.
REQ-031 Busy-ignore: pulse tx_valid with 8'h55 at cycle 40 of a frame carrying 8'h0F, and change data_in -> the 8'h0F frame is unaltered and no second frame is sent.
REQ-032 Abort: assert rst at cycle 70 of an 8'hC3 frame -> tx=1 at once, no done pulse. Then send 8'h81 -> correct frame and a single done pulse.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_pkg
// Frame and state definitions shared by the UART transmitter and the matching
// receiver. Changing OVERSAMPLE here changes both ends together, so the
// transmitter and receiver always use the same clk cycles per bit.
// Contents:
//   state_e      - IDLE/START/DATA/STOP state encodings
//   OVERSAMPLE   - clk cycles per UART bit (16)
//   DATA_BITS    - data bits per frame (8), sent LSB first
//   STOP_BITS    - stop bits per frame (1)
//   CNT_W/IDX_W  - widths of the bit-period counter and the bit index
//   CNT_LAST/IDX_LAST - terminal values of those two counters
// -----------------------------------------------------------------------------
package uart_tx_pkg;

  localparam int OVERSAMPLE   = 16;
  localparam int DATA_BITS    = 8;
  localparam int STOP_BITS    = 1;
  localparam int FRAME_CYCLES = OVERSAMPLE * (1 + DATA_BITS + STOP_BITS);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

endpackage

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// 8N1 UART transmitter with a 16x oversampled bit period. A byte is accepted on
// a rising edge where tx_valid && tx_ready; the frame (start, 8 data bits LSB
// first, 1 stop bit) then takes exactly 160 cycles, after which the block is
// back in IDLE and done pulses for one cycle. tx_valid while busy is ignored.
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-high reset; aborts any frame in flight
//   data_in  - byte to send, sampled only on the accept edge
//   tx_valid - upstream has a byte for us
//   tx_ready - high exactly in IDLE (combinational from state)
//   tx       - serial line, registered, idles high
//   busy     - high whenever not IDLE
//   done     - registered one-cycle pulse after the stop bit completes
// -----------------------------------------------------------------------------
module uart_tx
  import uart_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;

  logic accept;
  logic cnt_last;
  logic idx_last;

  assign accept   = tx_valid && tx_ready;
  assign cnt_last = (cnt_q == CNT_LAST);
  assign idx_last = (idx_q == IDX_LAST);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept)               state_d = ST_START;
      ST_START: if (cnt_last)             state_d = ST_DATA;
      ST_DATA:  if (cnt_last && idx_last) state_d = ST_STOP;
      ST_STOP:  if (cnt_last)             state_d = ST_IDLE;
      default:                            state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs decoded from state
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_ready = (state_q == ST_IDLE);
    busy     = (state_q != ST_IDLE);
  end

  assign tx   = tx_q;
  assign done = done_q;

  // ---------------------------------------------------------------------------
  // Datapath: bit-period counter, bit index, shift register, line level.
  // tx_d is always the level for the *next* bit period, so the line changes on
  // the same edge as the state and never passes through combinational logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          shreg_d = data_in;
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_last) begin
          cnt_d = '0;
          tx_d  = shreg_q[0];
        end
      end
      ST_DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_last) begin
          cnt_d = '0;
          if (!idx_last) begin
            idx_d   = idx_q + 1'b1;
            // Bit 0 of the shift register is the bit currently on the line,
            // so the next one to drive is bit 1 before the shift lands.
            shreg_d = {1'b0, shreg_q[7:1]};
            tx_d    = shreg_q[1];
          end else begin
            tx_d = 1'b1;
          end
        end
      end
      ST_STOP: begin
        cnt_d = cnt_q + 1'b1;
        tx_d  = 1'b1;
        if (cnt_last) begin
          cnt_d  = '0;
          done_d = 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        idx_d   = '0;
        shreg_d = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Directed, table-driven bench for uart_tx. Each table row carries a byte, the
// hand-computed 10-bit line pattern (start..stop, leftmost = start bit) and an
// optional cycle at which a stray tx_valid is pulsed mid-frame. A small
// behavioural receiver on the same clock decodes the line independently.
// Hand-written sequences cover back-to-back frames and a mid-frame reset.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  uart_tx dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural receiver: waits for a low level, samples mid-bit every 16
  // cycles, stores the byte if the stop bit is high.
  // ---------------------------------------------------------------------------
  logic       rx_active = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_shift = 8'h00;
  logic [7:0] rx_bytes [0:31];
  int         rx_n = 0;
  int         rx_stop_err = 0;
  int         done_total = 0;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      rx_active <= 1'b0;
      rx_cnt    <= 0;
    end else if (!rx_active) begin
      if (tx === 1'b0) begin
        rx_active <= 1'b1;
        rx_cnt    <= 1;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt == 8) begin
        if (tx !== 1'b0) rx_active <= 1'b0;
      end else if (rx_cnt >= 24 && rx_cnt <= 136 && ((rx_cnt - 8) % 16) == 0) begin
        rx_shift <= {tx, rx_shift[7:1]};
      end else if (rx_cnt == 152) begin
        rx_active <= 1'b0;
        if (tx === 1'b1) begin
          rx_bytes[rx_n % 32] <= rx_shift;
          rx_n <= rx_n + 1;
        end else begin
          rx_stop_err <= rx_stop_err + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done === 1'b1) done_total <= done_total + 1;
  end

  // ---------------------------------------------------------------------------
  // One full frame. Called at a negedge with tx_ready expected high; the accept
  // happens on the very next rising edge. Returns at the negedge of cycle 161,
  // i.e. in the first cycle back in IDLE.
  // ---------------------------------------------------------------------------
  task automatic run_frame(input logic [7:0] d, input logic [9:0] exp_bits,
                           input int inject, input string tag);
    logic line [1:161];
    logic busy_ok;
    logic done_last;
    logic held_ok;
    int   done_n;
    int   rx_before;
    rx_before = rx_n;
    data_in   = d;
    tx_valid  = 1'b1;
    check({tag, "/ready"}, tx_ready, 1);
    @(posedge clk);
    busy_ok = 1'b1;
    done_n  = 0;
    for (int c = 1; c <= 161; c++) begin
      @(negedge clk);
      line[c] = tx;
      if (c <= 160 && busy !== 1'b1) busy_ok = 1'b0;
      if (c == 161 && busy !== 1'b0) busy_ok = 1'b0;
      if (done === 1'b1) done_n++;
      if (c == 1) begin
        tx_valid = 1'b0;
        data_in  = ~d;
      end
      if (inject != 0 && c == inject) begin
        tx_valid = 1'b1;
        data_in  = 8'h55;
      end
      if (inject != 0 && c == inject + 1) begin
        tx_valid = 1'b0;
        data_in  = 8'hAA;
      end
    end
    done_last = done;
    for (int b = 0; b < 10; b++) begin
      held_ok = 1'b1;
      for (int k = 1; k <= 16; k++)
        if (line[16*b + k] !== line[16*b + 1]) held_ok = 1'b0;
      check($sformatf("%s/bit%0d", tag, b), {held_ok, line[16*b + 1]}, {1'b1, exp_bits[9-b]});
    end
    check({tag, "/busy_1_to_160"}, busy_ok, 1);
    check({tag, "/done_once_at_161"}, done_n * 2 + int'(done_last), 3);
    check({tag, "/rx_count"}, rx_n - rx_before, 1);
    check({tag, "/rx_byte"}, rx_bytes[(rx_n + 31) % 32], d);
    $display("frame %s: data=0x%02h rx=0x%02h done_pulses=%0d", tag, d,
             rx_bytes[(rx_n + 31) % 32], done_n);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] bits;
    int         inject;
    string      tag;
  } vec_t;

  vec_t vecs [6];

  logic line2 [1:330];
  int   ones;
  int   rx_before;
  int   done_before;
  logic quiet_ok;

  initial begin
    // Hand-computed line patterns, leftmost bit = start bit.
    vecs[0] = '{8'hA5, 10'b0101001011, 0,  "A5"};
    vecs[1] = '{8'h3C, 10'b0001111001, 0,  "3C"};
    vecs[2] = '{8'h00, 10'b0000000001, 0,  "00"};
    vecs[3] = '{8'hFF, 10'b0111111111, 0,  "FF"};
    vecs[4] = '{8'h81, 10'b0100000011, 0,  "81"};
    vecs[5] = '{8'h0F, 10'b0111100001, 40, "0F_busy_ignore"};

    rst      = 1'b1;
    tx_valid = 1'b0;
    data_in  = 8'h00;
    #23;
    check("reset/outputs", {tx, tx_ready, busy, done}, 4'b1100);

    // First accept on the first edge after reset release.
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++)
      run_frame(vecs[i].data, vecs[i].bits, vecs[i].inject, vecs[i].tag);

    // The stray tx_valid during the 0F frame must not start another frame.
    rx_before = rx_n;
    quiet_ok  = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) quiet_ok = 1'b0;
    end
    check("busy_ignore/no_second_frame", {quiet_ok, 8'(rx_n - rx_before)}, {1'b1, 8'd0});

    // Back-to-back: tx_valid held high across both frames.
    rx_before   = rx_n;
    done_before = done_total;
    data_in     = 8'h00;
    tx_valid    = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 330; c++) begin
      @(negedge clk);
      line2[c] = tx;
      if (c == 1)   data_in  = 8'hFF;
      if (c == 162) tx_valid = 1'b0;
    end
    ones = 0;
    for (int c = 161; c >= 1; c--) begin
      if (line2[c] !== 1'b1) break;
      ones++;
    end
    check("b2b/first_start", line2[1], 0);
    check("b2b/second_fall_at_161", {line2[161], line2[162]}, 2'b10);
    check("b2b/high_gap", ones, 17);
    check("b2b/rx_count", rx_n - rx_before, 2);
    check("b2b/rx_byte0", rx_bytes[(rx_n + 30) % 32], 8'h00);
    check("b2b/rx_byte1", rx_bytes[(rx_n + 31) % 32], 8'hFF);
    check("b2b/done_count", done_total - done_before, 2);
    $display("frame b2b: 0x00 then 0xFF, high gap=%0d", ones);

    // Abort: reset at cycle 70 of a C3 frame.
    @(negedge clk);
    done_before = done_total;
    rx_before   = rx_n;
    data_in     = 8'hC3;
    tx_valid    = 1'b1;
    @(posedge clk);
    for (int c = 1; c < 70; c++) begin
      @(negedge clk);
      if (c == 1) tx_valid = 1'b0;
    end
    @(posedge clk);
    #2;
    check("abort/busy_before_reset", busy, 1);
    #1;
    rst = 1'b1;
    #1;
    check("abort/outputs_immediate", {tx, tx_ready, busy, done}, 4'b1100);
    @(posedge clk);
    #1;
    check("abort/outputs_held", {tx, tx_ready, busy, done}, 4'b1100);
    @(negedge clk);
    check("abort/no_done", done_total - done_before, 0);
    rst = 1'b0;
    run_frame(8'h81, 10'b0100000011, 0, "81_after_abort");
    check("abort/no_partial_rx", rx_n - rx_before, 1);
    $display("frame abort: 0xC3 discarded at cycle 70, then 0x81 sent");

    check("rx/stop_errors", rx_stop_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
